// File: rtl/recip_prep.sv
// Front end of the Newton-Raphson reciprocal: decodes a binary64 divisor to a Q9.55
// mantissa, seeds the reciprocal unit from a small LUT and returns 1/M with exponent and flags.
module recip_prep #(
    parameter int SEED_IDX = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_divisor,
    output logic        rcp_start,
    output logic [63:0] rcp_x,
    output logic [63:0] rcp_d,
    input  logic [63:0] rcp_result,
    input  logic        rcp_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_recip,
    output logic [11:0] out_exp,
    output logic        out_sign,
    output logic [3:0]  out_flags
);

    localparam int N_SEED = 1 << SEED_IDX;
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    // Seed S_i = round(256 / midpoint of LUT interval i); evaluated only at elaboration.
    function automatic logic [7:0] seed_val(input int i);
        int den;
        int s;
        den = 2 * N_SEED + 2 * i + 1;
        s   = (1024 * N_SEED + den) / (2 * den);
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    function automatic logic [5:0] lzc52(input logic [51:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd52;
        found = 1'b0;
        for (int b = 51; b >= 0; b--) begin
            if (!found && v[b]) begin
                n     = 6'(51 - b);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic [7:0] seed_lut [N_SEED];
    for (genvar g = 0; g < N_SEED; g++) begin : g_seed
        assign seed_lut[g] = seed_val(g);
    end

    logic [2:0]      state_q,  state_d;
    logic [63:0]     div_q,    div_d;
    logic [63:0]     rcp_x_q,  rcp_x_d;
    logic [63:0]     rcp_d_q,  rcp_d_d;
    logic [63:0]     recip_q,  recip_d;
    logic [11:0]     exp_q,    exp_d;
    logic            sign_q,   sign_d;
    logic [3:0]      flags_q,  flags_d;
    logic [WD_W-1:0] wd_q,     wd_d;

    logic [10:0]         dec_exp;
    logic [51:0]         dec_mant;
    logic [5:0]          dec_lz;
    logic                dec_sub;
    logic [51:0]         dec_frac;
    logic [63:0]         dec_m;
    logic [63:0]         dec_x;
    logic [SEED_IDX-1:0] dec_idx;
    logic [11:0]         dec_nexp;

    // Subnormals shift their leading one out of the fraction so it becomes the hidden bit.
    always_comb begin
        dec_exp  = div_q[62:52];
        dec_mant = div_q[51:0];
        dec_lz   = lzc52(dec_mant);
        dec_sub  = (dec_exp == 11'd0);
        dec_frac = dec_sub ? (dec_mant << (dec_lz + 6'd1)) : dec_mant;
        dec_m    = {8'b0, 1'b1, dec_frac, 3'b0};
        dec_idx  = dec_m[54 -: SEED_IDX];
        dec_x    = {9'b0, seed_lut[dec_idx], 47'b0};
        dec_nexp = dec_sub ? (12'd1023 + {6'b0, dec_lz}) : (12'd1023 - {1'b0, dec_exp});
    end

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path through
        // the case statement can leave a signal unassigned and infer a latch.
        state_d = state_q;
        div_d   = div_q;
        rcp_x_d = rcp_x_q;
        rcp_d_d = rcp_d_q;
        recip_d = recip_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        flags_d = flags_q;
        wd_d    = wd_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    div_d   = in_divisor;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                sign_d  = div_q[63];
                flags_d = 4'b0000;
                if (dec_exp == 11'h7FF) begin
                    flags_d = (dec_mant != 52'd0) ? 4'b0100 : 4'b0001;
                    recip_d = 64'd0;
                    exp_d   = 12'd0;
                    state_d = S_OUT;
                end else if (dec_sub && dec_mant == 52'd0) begin
                    flags_d = 4'b0010;
                    recip_d = 64'd0;
                    exp_d   = 12'd0;
                    state_d = S_OUT;
                end else begin
                    rcp_d_d = dec_m;
                    rcp_x_d = dec_x;
                    exp_d   = dec_nexp;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rcp_done) begin
                    recip_d = rcp_result;
                    state_d = S_OUT;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    flags_d = 4'b1000;
                    recip_d = 64'd0;
                    state_d = S_OUT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    flags_d = 4'b0000;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            div_q   <= 64'd0;
            rcp_x_q <= 64'd0;
            rcp_d_q <= 64'd0;
            recip_q <= 64'd0;
            exp_q   <= 12'd0;
            sign_q  <= 1'b0;
            flags_q <= 4'b0000;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rcp_x_q <= rcp_x_d;
            rcp_d_q <= rcp_d_d;
            recip_q <= recip_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            flags_q <= flags_d;
            wd_q    <= wd_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign rcp_start = (state_q == S_ISSUE);
    assign out_valid = (state_q == S_OUT);
    assign rcp_x     = rcp_x_q;
    assign rcp_d     = rcp_d_q;
    assign out_recip = recip_q;
    assign out_exp   = exp_q;
    assign out_sign  = sign_q;
    assign out_flags = flags_q;

endmodule

// File: tb/tb_recip_prep.sv
// Scoreboard bench for recip_prep: a reference model predicts seeds and results, a stub
// reciprocal unit answers start pulses, and monitors compare what the DUT presents.
module tb_recip_prep;

    localparam int SEED_IDX = 4;
    localparam int TIMEOUT  = 16;
    localparam int N_SEED   = 1 << SEED_IDX;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_divisor = 64'd0;
    logic        rcp_start;
    logic [63:0] rcp_x;
    logic [63:0] rcp_d;
    logic [63:0] rcp_result = 64'd0;
    logic        rcp_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_recip;
    logic [11:0] out_exp;
    logic        out_sign;
    logic [3:0]  out_flags;

    recip_prep #(.SEED_IDX(SEED_IDX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_divisor(in_divisor),
        .rcp_start(rcp_start), .rcp_x(rcp_x), .rcp_d(rcp_d),
        .rcp_result(rcp_result), .rcp_done(rcp_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_recip(out_recip),
        .out_exp(out_exp), .out_sign(out_sign), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [63:0] recip;
        logic [11:0] oexp;
        bit          chk_exp;
        logic        sign;
        logic [3:0]  flags;
        int          lat;
        int          acc;
    } out_t;

    typedef struct {
        logic [63:0] x;
        logic [63:0] d;
    } iss_t;

    out_t out_q[$];
    iss_t iss_q[$];

    bit stub_on   = 1'b1;
    bit bp_en     = 1'b0;
    bit force_low = 1'b0;
    int late_req  = 0;

    // Reference: value-level normalisation (double until >= 2^52), seed from the
    // interval-midpoint formula, exact truncated 2^110 / M from an ideal reciprocal unit.
    function automatic void model(input logic [63:0] dv, input bit respond,
                                  output out_t o, output bit special, output iss_t is);
        logic [10:0]  ex;
        logic [51:0]  mn;
        logic [63:0]  m;
        logic [127:0] num;
        int e, idx, s;
        ex = dv[62:52];
        mn = dv[51:0];
        o.sign = dv[63]; o.oexp = 12'd0; o.chk_exp = 1'b0; o.recip = 64'd0;
        o.flags = 4'b0000; o.lat = 1; o.acc = 0;
        special = 1'b1; is.x = 64'd0; is.d = 64'd0;
        if (ex == 11'h7FF) begin
            o.flags = (mn != 52'd0) ? 4'b0100 : 4'b0001;
        end else if (ex == 11'd0 && mn == 52'd0) begin
            o.flags = 4'b0010;
        end else begin
            special = 1'b0;
            if (ex != 11'd0) begin
                m = 64'(mn) | (64'd1 << 52);
                e = int'(ex) - 1023;
            end else begin
                m = 64'(mn);
                e = -1022;
                while (m < (64'd1 << 52)) begin
                    m = m << 1;
                    e--;
                end
            end
            is.d = m << 3;
            idx  = int'((is.d - (64'd1 << 55)) >> (55 - SEED_IDX));
            s    = $rtoi(8192.0 / real'(2 * idx + 33) + 0.5);
            is.x = 64'(s) << 47;
            o.chk_exp = 1'b1;
            o.oexp    = 12'(-e);
            if (respond) begin
                num     = 128'd1 << 110;
                o.recip = 64'(num / {64'd0, is.d});
                o.lat   = 7;
            end else begin
                o.flags = 4'b1000;
                o.lat   = -1;
            end
        end
    endfunction

    // Stub reciprocal unit: 4 iteration cycles after sampling start, then a done pulse.
    initial begin
        logic [63:0]  dcap;
        logic [127:0] num;
        int served = 0;
        forever begin
            @(negedge clk);
            if (late_req != served) begin
                served = late_req;
                @(posedge clk); #1;
                rcp_result = {$urandom, $urandom};
                rcp_done = 1'b1;
                @(posedge clk); #1;
                rcp_done = 1'b0;
            end else if (rcp_start && stub_on && reset_n) begin
                dcap = rcp_d;
                repeat (5) @(posedge clk);
                #1;
                num = 128'd1 << 110;
                rcp_result = (dcap == 64'd0) ? 64'd0 : 64'(num / {64'd0, dcap});
                rcp_done = 1'b1;
                @(posedge clk); #1;
                rcp_done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            out_ready = force_low ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Issue monitor: seed and mantissa on the start pulse, pulse width, hold afterwards.
    initial begin
        iss_t it;
        bit pend = 1'b0;
        logic [63:0] px, pd;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pend = 1'b0;
            end else if (pend) begin
                check("start_single_pulse", 64'(rcp_start), 64'd0);
                check("rcp_x_held", rcp_x, px);
                check("rcp_d_held", rcp_d, pd);
                pend = 1'b0;
            end else if (rcp_start) begin
                if (iss_q.size() == 0) begin
                    check("start_unexpected", 64'(rcp_start), 64'd0);
                end else begin
                    it = iss_q.pop_front();
                    check("rcp_x", rcp_x, it.x);
                    check("rcp_d", rcp_d, it.d);
                end
                px = rcp_x;
                pd = rcp_d;
                pend = 1'b1;
            end
        end
    end

    // Output monitor: latency at out_valid rise, full compare at the handshake.
    initial begin
        out_t o;
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (out_q.size() == 0)
                        check("out_unexpected", 64'(out_valid), 64'd0);
                    else if (out_q[0].lat >= 0)
                        check("latency", 64'(cyc - out_q[0].acc), 64'(out_q[0].lat));
                end
                if (out_valid && out_ready && out_q.size() > 0) begin
                    o = out_q.pop_front();
                    check("out_recip", out_recip, o.recip);
                    check("out_flags", 64'(out_flags), 64'(o.flags));
                    check("out_sign", 64'(out_sign), 64'(o.sign));
                    if (o.chk_exp) check("out_exp", 64'(out_exp), 64'(o.oexp));
                end
                prev = out_valid;
            end
        end
    end

    task automatic send(input logic [63:0] dv);
        out_t o;
        iss_t is;
        bit sp;
        int n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("send_wait_ready", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_divisor = dv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model(dv, stub_on, o, sp, is);
        o.acc = cyc;
        out_q.push_back(o);
        if (!sp) iss_q.push_back(is);
    endtask

    task automatic drain();
        int n = 0;
        while ((out_q.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(out_q.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_rcp_start"}, 64'(rcp_start), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_rcp_x"},     rcp_x,          64'd0);
        check({tag, "_rcp_d"},     rcp_d,          64'd0);
        check({tag, "_out_recip"}, out_recip,      64'd0);
        check({tag, "_out_exp"},   64'(out_exp),   64'd0);
        check({tag, "_out_sign"},  64'(out_sign),  64'd0);
        check({tag, "_out_flags"}, 64'(out_flags), 64'd0);
    endtask

    function automatic logic [63:0] rand_divisor();
        logic [63:0] r;
        logic [51:0] mn;
        logic [10:0] ex;
        int cls;
        r   = {$urandom, $urandom};
        mn  = r[51:0];
        cls = $urandom_range(0, 9);
        case (cls)
            0: begin ex = 11'd0;     mn = 52'd0; end
            1: begin ex = 11'h7FF;   mn = 52'd0; end
            2: begin ex = 11'h7FF;   if (mn == 52'd0) mn = 52'd1; end
            3, 4: begin
                ex = 11'd0;
                mn = mn >> $urandom_range(0, 51);
                if (mn == 52'd0) mn = 52'd1;
            end
            default: ex = 11'($urandom_range(1, 2046));
        endcase
        return {r[63], ex, mn};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish (checks %0d)", checks);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [63:0] snap_recip;
        logic [17:0] snap_side;
        int n;

        #12;
        check_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases from the plan.
        send(64'h4000_0000_0000_0000);
        send(64'hBFF8_0000_0000_0000);
        send(64'h0008_0000_0000_0000);
        send(64'h0000_0000_0000_0000);
        send(64'h7FF0_0000_0000_0000);
        send(64'h7FF8_0000_0000_0000);
        send(64'h8000_0000_0000_0001);
        drain();

        // Backpressure hold: outputs frozen, no new acceptance, in_ready one cycle after release.
        force_low = 1'b1;
        send(64'h3FF4_0000_0000_0000);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid_seen", 64'(out_valid), 64'd1);
        snap_recip = out_recip;
        snap_side  = {out_exp, out_sign, out_flags, out_valid};
        in_valid   = 1'b1;
        in_divisor = 64'h4010_0000_0000_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_recip", out_recip, snap_recip);
            check("hold_side", 64'({out_exp, out_sign, out_flags, out_valid}), 64'(snap_side));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        force_low = 1'b0;
        @(posedge clk); #1;
        check("ready_after_release", 64'(in_ready), 64'd1);
        check("valid_after_release", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        drain();

        // Missing done: watchdog fires, then a late done in IDLE is ignored.
        stub_on = 1'b0;
        send(64'h4000_0000_0000_0000);
        drain();
        late_req = late_req + 1;
        repeat (4) begin
            @(negedge clk);
            check("late_done_valid", 64'(out_valid), 64'd0);
            check("late_done_ready", 64'(in_ready), 64'd1);
        end

        // Reset in the middle of WAIT aborts the operand.
        send(64'hC008_0000_0000_0000);
        repeat (6) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("midwait");
        out_q.delete();
        iss_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        stub_on = 1'b1;

        // Randomised operands with random backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 40; i++) send(rand_divisor());
        drain();
        bp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/recip_prep.md
Name: recip_prep

Overview:
- Front-end stage for the Newton-Raphson reciprocal unit in the FP divide path.
- Accepts an IEEE-754 binary64 divisor over a valid/ready handshake. Decodes and normalises it, including subnormals, to a Q9.55 mantissa M in [1,2).
- Produces a LUT seed X0 ≈ 1/M, launches the reciprocal unit with a start pulse, and waits for its done pulse.
- Returns the Q9.55 reciprocal plus exponent, sign and special-case flags to the downstream multiply/round stage.

Parameters:
- SEED_IDX, 4, number of leading fraction bits indexing the seed LUT (2^SEED_IDX entries).
- TIMEOUT, 16, WAIT-state cycles allowed before rcp_done is declared missing.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  divisor valid.
- in_ready  out  1  stage can accept a divisor.
- in_divisor  in  64  binary64 divisor.
- rcp_start  out  1  one-cycle start pulse to the reciprocal unit.
- rcp_x  out  64  Q9.55 initial guess X0.
- rcp_d  out  64  Q9.55 normalised divisor M.
- rcp_result  in  64  Q9.55 reciprocal from the reciprocal unit.
- rcp_done  in  1  reciprocal-valid pulse.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_recip  out  64  Q9.55 value of 1/M, in (0.5,1].
- out_exp  out  12  signed exponent; result = out_recip × 2^out_exp.
- out_sign  out  1  divisor sign, passed through.
- out_flags  out  4  {timeout, nan, div_by_zero, inf_in}.

Behaviour:
- One clock domain. Reset is asynchronous, active-low.
- Reset values:
  - state IDLE.
  - in_ready=1; rcp_start=0; out_valid=0.
  - rcp_x, rcp_d, out_recip, out_exp, out_sign, out_flags all 0.
  - Watchdog counter 0.
- The reciprocal unit shares the same reset. Reset mid-operation aborts everything; no output is produced for an in-flight operand.
- FSM states: IDLE, DECODE, ISSUE, WAIT, OUT.
  - IDLE:
    - in_ready=1.
    - On in_valid, capture in_divisor and go to DECODE.
    - in_ready=0 in all other states.
  - DECODE (1 cycle): classify the operand and register results.
    - NaN (exp=0x7FF, mant≠0): out_flags.nan=1, out_recip=0, go to OUT.
    - Inf (exp=0x7FF, mant=0): inf_in=1, out_recip=0, go to OUT.
    - Zero (exp=0, mant=0): div_by_zero=1, out_recip=0, go to OUT.
    - Normal: M = {8'b0, 1'b1, mant, 3'b0}; e = exp−1023.
    - Subnormal: left-shift mant by lzc(mant)+1 so the hidden one is at bit 55; e = −1022 − (lzc(mant)+1). The shift is combinational in DECODE.
    - Seed index i = top SEED_IDX fraction bits of normalised M. X0 = S_i × 2^−8, placed at Q9.55 bits [54:47], with S_i = round(8192/(2i+33)).
      - Default 16-entry table runs from S_0=248 to S_15=130; S_8=167.
    - out_exp = −e.
    - out_sign = in_divisor[63] for every class.
    - Normal and subnormal operands go to ISSUE.
  - ISSUE (1 cycle):
    - rcp_start=1 for exactly this cycle.
    - rcp_x and rcp_d are driven, and held stable from ISSUE through WAIT.
    - Go to WAIT; clear the watchdog.
  - WAIT:
    - On rcp_done: out_recip ← rcp_result; go to OUT.
    - Otherwise increment the watchdog. At TIMEOUT: timeout=1, out_recip=0, go to OUT.
  - OUT:
    - out_valid=1. All out_* held stable while out_ready=0.
    - On out_ready: out_valid=0, flags clear, go to IDLE.
    - in_ready rises only the cycle after the handshake; no bypass.
- Latency, with the reciprocal unit taking 4 iteration cycles:
  - Normal/subnormal: out_valid high after the 7th clock edge following the accepting edge.
  - Special cases: out_valid high after the 1st edge following the accepting edge.
- rcp_done outside WAIT is ignored, e.g. a late done after a timeout.
- Throughput: one operand in flight; no overlap.

Test Plan:
- Divisor 2.0, in_divisor=0x4000000000000000 -> rcp_d=0x0080000000000000, rcp_x=0x007C000000000000 (248/256), single rcp_start pulse. Result: out_recip=0x0080000000000000 ±1 LSB, out_exp=−1, flags=0, out_valid on the 7th edge.
- Divisor −1.5, in_divisor=0xBFF8000000000000 -> seed index 8, rcp_x=0x0053800000000000. Result: out_recip≈0x0055555555555555 ±2 LSB, out_exp=0, out_sign=1.
- Subnormal 0x0008000000000000 -> rcp_d=0x0080000000000000, out_exp=+1023, out_recip=1.0.
- Zero, Inf (0x7FF0000000000000) and NaN (0x7FF8000000000000) -> rcp_start never asserted. Respectively: div_by_zero=1, inf_in=1, nan=1; out_recip=0; out_valid after 1 edge.
- Hold out_ready low 10 cycles in OUT -> all outputs stable, in_ready=0, a new in_valid is not accepted. After release, in_ready=1 on the next cycle.
- Stubbed reciprocal unit never pulses done -> out_flags=4'b1000 after TIMEOUT=16 WAIT cycles. A late rcp_done in IDLE is ignored. Assert reset_n mid-WAIT -> all outputs return to reset values immediately.
